// File: rtl/ifg.sv
// Fetch PC generator: issues 8-byte-aligned imem reads and packs each 1-cycle-late fetch group into a dual-slot packet.
// Credit rule on ifb_full/ifb_afull keeps the fetch buffer from overflowing; redirect squashes the response due this cycle.
package ifg_pkg;
  typedef struct packed {
    logic        i0_valid;
    logic        i1_valid;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] pc;
  } inst_pkt_t;
endpackage

module ifg
  import ifg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ifb_full,
  input  logic        ifb_afull,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [63:0] imem_rdata,
  output inst_pkt_t   out_inst_p
);

  logic [31:2] r_pc;
  logic [31:2] r_resp_pc;
  logic        r_inflight;
  logic        issue;
  logic        unused_lsbs;

  assign unused_lsbs = ^redirect_pc[1:0];

  // An in-flight response plus an almost-full buffer would fill it, so hold off.
  assign issue = !rst && !redirect_valid && !ifb_full && !(ifb_afull && r_inflight);

  assign imem_req  = issue;
  assign imem_addr = {r_pc[31:3], 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC[31:2];
      r_resp_pc  <= RESET_PC[31:2];
      r_inflight <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc[31:2];
      r_inflight <= 1'b0;
    end else if (issue) begin
      r_inflight <= 1'b1;
      r_resp_pc  <= r_pc;
      r_pc       <= {r_pc[31:3] + 29'd1, 1'b0};
    end else begin
      r_inflight <= 1'b0;
    end
  end

  always_comb begin
    out_inst_p          = '0;
    out_inst_p.i1_valid = r_inflight && !redirect_valid;
    // Entry at an odd word leaves slot 0 empty.
    out_inst_p.i0_valid = out_inst_p.i1_valid && !r_resp_pc[2];
    out_inst_p.i0       = imem_rdata[31:0];
    out_inst_p.i1       = imem_rdata[63:32];
    out_inst_p.pc       = {r_resp_pc[31:3], 3'b000};
  end

endmodule

// File: tb/tb_ifg.sv
// Directed bench for ifg: a 2-entry fetch buffer model supplies full/afull, a tagged imem answers requests.
module tb_ifg;
  import ifg_pkg::*;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifb_full;
  logic        ifb_afull;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [63:0] imem_rdata;
  inst_pkt_t   out_inst_p;

  logic        drain;
  logic        push;
  logic        pop;
  int          cnt;
  int          n_cmp;
  int          n_fail;
  inst_pkt_t   exp_q[$];

  ifg #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .ifb_full(ifb_full),
    .ifb_afull(ifb_afull),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .out_inst_p(out_inst_p)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Fetch buffer model: 2 entries, flow-through pop, flushed by redirect.
  assign push      = out_inst_p.i0_valid || out_inst_p.i1_valid;
  assign pop       = drain && (cnt != 0 || push);
  assign ifb_full  = (cnt >= 2);
  assign ifb_afull = (cnt == 1);

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if (redirect_valid) cnt <= 0;
    else cnt <= cnt + int'(push) - int'(pop);
  end

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= {tag(imem_addr + 32'd4), tag(imem_addr)};
  end

  // Monitor: pops the expected packet whenever the DUT pushes one.
  always @(negedge clk) begin
    #2;
    if (!rst && push) begin
      chk("no_overflow", {31'd0, (cnt >= 2 && !pop)}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pkt_pc", out_inst_p.pc, 32'hFFFF_FFFF);
      end else begin
        inst_pkt_t e;
        e = exp_q.pop_front();
        chk("pkt_pc", out_inst_p.pc, e.pc);
        chk("pkt_i0_valid", {31'd0, out_inst_p.i0_valid}, {31'd0, e.i0_valid});
        chk("pkt_i1_valid", {31'd0, out_inst_p.i1_valid}, {31'd0, e.i1_valid});
        if (e.i0_valid) chk("pkt_i0", out_inst_p.i0, e.i0);
        chk("pkt_i1", out_inst_p.i1, e.i1);
      end
    end
  end

  // One cycle: apply inputs, check request, and queue the packet due this cycle (or check none).
  task automatic cyc(input logic rv, input logic [31:0] rpc, input logic dr,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic pk, input logic [31:0] ppc, input logic pi0v);
    inst_pkt_t e;
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    drain          = dr;
    #1;
    chk("imem_req", {31'd0, imem_req}, {31'd0, ereq});
    if (ereq) chk("imem_addr", imem_addr, eaddr);
    if (pk) begin
      e.i0_valid = pi0v;
      e.i1_valid = 1'b1;
      e.i0       = tag(ppc);
      e.i1       = tag(ppc + 32'd4);
      e.pc       = ppc;
      exp_q.push_back(e);
    end else begin
      chk("no_pkt_valid", {30'd0, out_inst_p.i0_valid, out_inst_p.i1_valid}, 32'd0);
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    drain          = 1'b1;
    #3;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valids", {30'd0, out_inst_p.i0_valid, out_inst_p.i1_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    // c1: first request right after release
    chk("c1_imem_req", {31'd0, imem_req}, 32'd1);
    chk("c1_imem_addr", imem_addr, 32'h0000_0100);
    chk("c1_no_pkt", {31'd0, out_inst_p.i1_valid}, 32'd0);
    //  rv  rpc            dr   req  addr           pk   ppc            i0v
    cyc(0, 32'h0,          1,   1, 32'h0000_0108,  1, 32'h0000_0100, 1);  // c2
    cyc(0, 32'h0,          1,   1, 32'h0000_0110,  1, 32'h0000_0108, 1);  // c3
    cyc(0, 32'h0,          1,   1, 32'h0000_0118,  1, 32'h0000_0110, 1);  // c4
    cyc(1, 32'h0000_0204,  1,   0, 32'h0,          0, 32'h0,         0);  // c5 redirect
    cyc(0, 32'h0,          1,   1, 32'h0000_0200,  0, 32'h0,         0);  // c6
    cyc(0, 32'h0,          1,   1, 32'h0000_0208,  1, 32'h0000_0200, 0);  // c7 odd entry
    cyc(0, 32'h0,          0,   1, 32'h0000_0210,  1, 32'h0000_0208, 1);  // c8 stop draining
    cyc(0, 32'h0,          0,   0, 32'h0,          1, 32'h0000_0210, 1);  // c9 afull+inflight
    cyc(0, 32'h0,          0,   0, 32'h0,          0, 32'h0,         0);  // c10 full
    cyc(0, 32'h0,          1,   0, 32'h0,          0, 32'h0,         0);  // c11 pop one
    cyc(0, 32'h0,          0,   1, 32'h0000_0218,  0, 32'h0,         0);  // c12 resume
    cyc(0, 32'h0,          0,   0, 32'h0,          1, 32'h0000_0218, 1);  // c13
    cyc(1, 32'hFFFF_FFF8,  0,   0, 32'h0,          0, 32'h0,         0);  // c14 redirect while full
    cyc(0, 32'h0,          1,   1, 32'hFFFF_FFF8,  0, 32'h0,         0);  // c15
    cyc(0, 32'h0,          1,   1, 32'h0000_0000,  1, 32'hFFFF_FFF8, 1);  // c16 wrap
    cyc(0, 32'h0,          1,   1, 32'h0000_0008,  1, 32'h0000_0000, 1);  // c17
    // async reset pulse mid-cycle with 0x8 in flight
    #2 rst = 1'b1;
    #1;
    chk("arst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valids", {30'd0, out_inst_p.i0_valid, out_inst_p.i1_valid}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst_restart_req", {31'd0, imem_req}, 32'd1);
    chk("arst_restart_addr", imem_addr, 32'h0000_0100);
    cyc(0, 32'h0,          1,   1, 32'h0000_0108,  1, 32'h0000_0100, 1);  // c18
    cyc(0, 32'h0,          1,   1, 32'h0000_0110,  1, 32'h0000_0108, 1);  // c19
    cyc(1, 32'h0000_0400,  1,   0, 32'h0,          0, 32'h0,         0);  // c20 squash 0x110
    @(negedge clk);
    #3;
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifg.md
Name: ifg

Overview:
ifg is the instruction fetch generator (ifu front end), directly upstream of the instruction fetch buffer. It holds the fetch PC and issues 8-byte-aligned read requests to a synchronous instruction memory with fixed 1-cycle latency. It packs the returned 64-bit fetch group into a dual-slot instruction packet (in_inst_p of the fetch buffer). It applies fetch-buffer backpressure so the buffer is never pushed while full, and handles redirects from the branch unit.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] ignored.

Ports:
clk  in  1  clock
rst  in  1  reset
redirect_valid  in  1  redirect fetch (same signal drives fetch buffer flush)
redirect_pc  in  32  redirect target; bits [1:0] ignored
ifb_full  in  1  fetch buffer full
ifb_afull  in  1  fetch buffer almost full (one entry used)
imem_req  out  1  read request this cycle
imem_addr  out  32  request address, bits [2:0] always 0
imem_rdata  in  64  read data, valid the cycle after imem_req; word at addr in [31:0], addr+4 in [63:32]
out_inst_p  out  inst_pkt_t  packet to fetch buffer; fields i0_valid, i1_valid, i0 (32), i1 (32), pc (32, address of i0 slot)

Behaviour:
- Reset: clk is the single clock; rst is asynchronous, active-high. Asserting rst immediately forces r_pc=RESET_PC, r_inflight=0, imem_req=0, out i0_valid=i1_valid=0. The first request is issued in the first cycle after deassertion.
- State: r_pc[31:2] (next fetch address), r_inflight (a response is due this cycle), r_resp_pc[31:2] (address of that request).
- Issue condition: issue = !redirect_valid && !ifb_full && !(ifb_afull && r_inflight).
  - This credit rule guarantees at most 2 buffer entries after all in-flight responses land.
  - It holds with no consumption at the buffer output.
- imem_req = issue; imem_addr = {r_pc[31:3], 3'b000}.
- On issue edge: r_inflight<=1; r_resp_pc<=r_pc; r_pc<={r_pc[31:3]+1, 3'b000}.
  - This clears bit 2.
  - Address wraps 32'hFFFF_FFF8 -> 32'h0000_0000 with no flag.
- No issue, no redirect: r_inflight<=0; r_pc unchanged.
- Output packet: present only in the cycle r_inflight=1.
  - i1_valid = r_inflight && !redirect_valid.
  - i0_valid = i1_valid && !r_resp_pc[2]. A fetch entered at an odd word yields only slot 1.
  - i0 = imem_rdata[31:0]; i1 = imem_rdata[63:32]; pc = {r_resp_pc[31:3], 3'b000}.
  - Data fields are don't-care when both valids are 0.
- Redirect (redirect_valid=1 in cycle N):
  - The response in cycle N is discarded (valids forced 0), since the buffer flushes that edge.
  - No request is issued in N.
  - At edge N: r_pc<=redirect_pc[31:2]; r_inflight<=0.
  - A request to the redirect target issues in N+1 (the buffer is empty after flush).
- Redirect has priority over ifb_full/ifb_afull. Back-to-back redirects: the last one wins; no request issues until the cycle after the last redirect.
- Full: no request is issued. The pending response, if any, still emits (the credit rule reserved its slot).
- Throughput: 1 packet/cycle when the buffer drains every cycle. Redirect-to-first-packet latency: 2 cycles.
- Assertion (not in reset): no cycle with out valid while ifb_full=1 and no pop possible. The bench checks the buffer never overflows.

Test Plan:
- Reset, RESET_PC=0x100, buffer always draining, imem returns addr-tagged data -> imem_addr 0x100,0x108,0x110 on cycles 1,2,3; packets pc 0x100/0x108, both valids 1, one per cycle from cycle 2.
- Redirect to 0x204 in cycle N -> imem_req=0 in N, valids 0 in N; imem_addr=0x200 in N+1; packet N+2 has i0_valid=0, i1_valid=1, pc 0x200; next imem_addr 0x208.
- Buffer never drains, run from reset -> exactly 2 packets pushed, then imem_req stays 0 while ifb_full=1; no push while full. Release one entry -> requests resume at 0x110.
- ifb_afull=1 with r_inflight=1 -> imem_req=0 that cycle; response still emitted.
- Redirect asserted while ifb_full=1 -> redirect wins; request to target issues next cycle.
- r_pc=0xFFFF_FFF8 issue -> next imem_addr 0x0000_0000.
- Async rst pulse mid-cycle with request in flight -> imem_req and valids drop immediately; after release, fetch restarts at RESET_PC with no stale packet.
